// File: rtl/rtc_pkg.sv
// Shared types, field ranges and state encoding for the RTC time/date editor.
package rtc_pkg;

  localparam int FIELD_W  = 7;
  localparam int N_FIELDS = 6;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [2:0]         fidx_t;

  localparam fidx_t F_HOUR  = 3'd0;
  localparam fidx_t F_MIN   = 3'd1;
  localparam fidx_t F_SEC   = 3'd2;
  localparam fidx_t F_DAY   = 3'd3;
  localparam fidx_t F_MONTH = 3'd4;
  localparam fidx_t F_YEAR  = 3'd5;

  typedef enum logic [2:0] {
    ST_VIEW,
    ST_LOAD,
    ST_EDIT,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic field_t field_min(input fidx_t idx);
    case (idx)
      F_DAY, F_MONTH: return 7'd1;
      default:        return '0;
    endcase
  endfunction

  function automatic field_t field_max(input fidx_t idx);
    case (idx)
      F_HOUR:       return 7'd23;
      F_MIN, F_SEC: return 7'd59;
      F_DAY:        return 7'd31;
      F_MONTH:      return 7'd12;
      default:      return 7'd99;
    endcase
  endfunction

  // Out-of-range live values fall back to the field minimum.
  function automatic field_t field_clamp(input fidx_t idx, input field_t val);
    return (val < field_min(idx) || val > field_max(idx)) ? field_min(idx) : val;
  endfunction

endpackage

// File: rtl/field_step.sv
// Combinational +1/-1 of one field value with wrap at the field's legal range.
module field_step
  import rtc_pkg::*;
(
  input  fidx_t  idx_i,
  input  field_t val_i,
  output field_t inc_o,
  output field_t dec_o
);

  field_t lo;
  field_t hi;

  always_comb begin
    lo    = field_min(idx_i);
    hi    = field_max(idx_i);
    inc_o = (val_i >= hi) ? lo : val_i + 7'd1;
    dec_o = (val_i <= lo || val_i > hi) ? hi : val_i - 7'd1;
  end

endmodule

// File: rtl/rtc_edit_controller.sv
// Keyboard-driven edit session for RTC time/date: load, edit six fields, write back
// over a req/ack handshake with per-field timeout.
module rtc_edit_controller
  import rtc_pkg::*;
#(
  parameter int FIELD_W     = rtc_pkg::FIELD_W,
  parameter int N_FIELDS    = rtc_pkg::N_FIELDS,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                        Clock_i,
  input  logic                        Reset_n_i,
  input  logic                        arriba_i,
  input  logic                        abajo_i,
  input  logic                        izq_i,
  input  logic                        der_i,
  input  logic                        ent_i,
  input  logic [N_FIELDS*FIELD_W-1:0] cur_i,
  input  logic                        wr_ack_i,
  output logic                        edit_mode_o,
  output logic [2:0]                  cursor_o,
  output logic [N_FIELDS*FIELD_W-1:0] edit_data_o,
  output logic                        wr_req_o,
  output logic [2:0]                  wr_addr_o,
  output logic [FIELD_W-1:0]          wr_data_o,
  output logic                        done_o,
  output logic                        error_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e                            state_q, state_d;
  logic [N_FIELDS-1:0][FIELD_W-1:0]  buf_q, buf_d;
  fidx_t                             cursor_q, cursor_d;
  fidx_t                             wr_addr_q, wr_addr_d;
  field_t                            wr_data_q, wr_data_d;
  logic                              wr_req_q, wr_req_d;
  logic                              done_q, done_d;
  logic                              error_q, error_d;
  logic                              edit_mode_q, edit_mode_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  field_t sel_val, sel_inc, sel_dec;

  assign sel_val = buf_q[cursor_q];

  field_step u_step (
    .idx_i (cursor_q),
    .val_i (sel_val),
    .inc_o (sel_inc),
    .dec_o (sel_dec)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cursor_d = cursor_q;
    wr_addr_d = wr_addr_q;
    wr_req_d = wr_req_q;
    done_d   = 1'b0;
    error_d  = error_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_VIEW: begin
        if (ent_i) begin
          state_d = ST_LOAD;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        for (int unsigned k = 0; k < N_FIELDS; k++) begin
          buf_d[k] = field_clamp(fidx_t'(k), cur_i[k*FIELD_W +: FIELD_W]);
        end
        cursor_d = F_HOUR;
        state_d  = ST_EDIT;
      end
      ST_EDIT: begin
        // if/else chain encodes key priority: ent > arriba > abajo > izq > der.
        if (ent_i) begin
          wr_addr_d = F_HOUR;
          wr_req_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WRITE;
        end else if (arriba_i) begin
          buf_d[cursor_q] = sel_inc;
        end else if (abajo_i) begin
          buf_d[cursor_q] = sel_dec;
        end else if (izq_i) begin
          cursor_d = (cursor_q == F_HOUR) ? F_YEAR : cursor_q - 3'd1;
        end else if (der_i) begin
          cursor_d = (cursor_q == F_YEAR) ? F_HOUR : cursor_q + 3'd1;
        end
      end
      ST_WRITE: begin
        if (wr_ack_i) begin
          wr_req_d = 1'b0;
          if (wr_addr_q == F_YEAR) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            wr_addr_d = wr_addr_q + 3'd1;
            state_d   = ST_GAP;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          wr_req_d = 1'b0;
          error_d  = 1'b1;
          state_d  = ST_VIEW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        wr_req_d = 1'b1;
        cnt_d    = '0;
        state_d  = ST_WRITE;
      end
      ST_DONE: state_d = ST_VIEW;
      default: state_d = ST_VIEW;
    endcase

    edit_mode_d = (state_d == ST_LOAD) || (state_d == ST_EDIT) ||
                  (state_d == ST_WRITE) || (state_d == ST_GAP);
    wr_data_d   = buf_d[wr_addr_d];
  end

  always_ff @(posedge Clock_i) begin
    if (!Reset_n_i) begin
      state_q     <= ST_VIEW;
      buf_q       <= '0;
      cursor_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_req_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      edit_mode_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cursor_q    <= cursor_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_req_q    <= wr_req_d;
      done_q      <= done_d;
      error_q     <= error_d;
      edit_mode_q <= edit_mode_d;
      cnt_q       <= cnt_d;
    end
  end

  assign edit_mode_o = edit_mode_q;
  assign cursor_o    = cursor_q;
  assign edit_data_o = buf_q;
  assign wr_req_o    = wr_req_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_rtc_edit_controller.sv
// Self-checking bench: cycle-level behavioural model of the edit session plus directed scenarios.
module tb_rtc_edit_controller;

  localparam int TO = 8;
  localparam int P_VIEW = 0, P_LOAD = 1, P_EDIT = 2, P_WRITE = 3, P_GAP = 4, P_DONE = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arriba = 1'b0, abajo = 1'b0, izq = 1'b0, der = 1'b0, ent = 1'b0;
  logic        ack = 1'b0;
  logic [41:0] cur = '0;
  logic        edit_mode_o, wr_req_o, done_o, error_o;
  logic [2:0]  cursor_o, wr_addr_o;
  logic [41:0] edit_data_o;
  logic [6:0]  wr_data_o;

  always #5 clk = ~clk;

  rtc_edit_controller #(.TIMEOUT_CYC(TO)) dut (
    .Clock_i     (clk),
    .Reset_n_i   (rst_n),
    .arriba_i    (arriba),
    .abajo_i     (abajo),
    .izq_i       (izq),
    .der_i       (der),
    .ent_i       (ent),
    .cur_i       (cur),
    .wr_ack_i    (ack),
    .edit_mode_o (edit_mode_o),
    .cursor_o    (cursor_o),
    .edit_data_o (edit_data_o),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  int MINV[6] = '{0, 0, 0, 1, 1, 0};
  int MAXV[6] = '{23, 59, 59, 31, 12, 99};

  int ph = P_VIEW;
  int m_buf[6] = '{0, 0, 0, 0, 0, 0};
  int m_cur = 0, m_addr = 0, m_req = 0, m_done = 0, m_err = 0, m_wait = 0;

  int errs = 0, checks = 0;
  int ack_wait = -1, age = 0, m_was_req = 0;
  bit noise = 1'b0;
  bit prev_req = 1'b0;
  int req_cycles = 0, done_cnt = 0;
  int addr_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wrapv(input int k, input int v, input int d);
    int span;
    span = MAXV[k] - MINV[k] + 1;
    return MINV[k] + ((v - MINV[k] + d + span) % span);
  endfunction

  task automatic model_step();
    int v;
    if (!rst_n) begin
      ph = P_VIEW; m_cur = 0; m_addr = 0; m_req = 0; m_done = 0; m_err = 0; m_wait = 0;
      for (int k = 0; k < 6; k++) m_buf[k] = 0;
      return;
    end
    m_done = 0;
    case (ph)
      P_VIEW: if (ent) begin ph = P_LOAD; m_err = 0; end
      P_LOAD: begin
        for (int k = 0; k < 6; k++) begin
          v = int'(cur[7*k +: 7]);
          m_buf[k] = (v < MINV[k] || v > MAXV[k]) ? MINV[k] : v;
        end
        m_cur = 0;
        ph = P_EDIT;
      end
      P_EDIT: begin
        if (ent) begin m_addr = 0; m_req = 1; m_wait = 0; ph = P_WRITE; end
        else if (arriba) m_buf[m_cur] = wrapv(m_cur, m_buf[m_cur], 1);
        else if (abajo)  m_buf[m_cur] = wrapv(m_cur, m_buf[m_cur], -1);
        else if (izq)    m_cur = (m_cur + 5) % 6;
        else if (der)    m_cur = (m_cur + 1) % 6;
      end
      P_WRITE: begin
        if (ack) begin
          m_req = 0;
          if (m_addr == 5) begin ph = P_DONE; m_done = 1; end
          else begin ph = P_GAP; m_addr++; end
        end else begin
          m_wait++;
          if (m_wait == TO) begin m_req = 0; m_err = 1; ph = P_VIEW; end
        end
      end
      P_GAP:  begin ph = P_WRITE; m_req = 1; m_wait = 0; end
      default: ph = P_VIEW;
    endcase
  endtask

  task automatic check_outputs();
    logic [41:0] eb;
    for (int k = 0; k < 6; k++) eb[7*k +: 7] = 7'(m_buf[k]);
    chk("edit_mode", 64'(edit_mode_o), 64'(ph >= P_LOAD && ph <= P_GAP));
    chk("cursor", 64'(cursor_o), 64'(m_cur));
    chk("edit_data", 64'(edit_data_o), 64'(eb));
    chk("wr_req", 64'(wr_req_o), 64'(m_req));
    if (m_req != 0) begin
      chk("wr_addr", 64'(wr_addr_o), 64'(m_addr));
      chk("wr_data", 64'(wr_data_o), 64'(m_buf[m_addr]));
    end
    chk("done", 64'(done_o), 64'(m_done));
    chk("error", 64'(error_o), 64'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #4;
    check_outputs();
    if (wr_req_o && !prev_req) addr_log.push_back(int'(wr_addr_o));
    if (wr_req_o) req_cycles++;
    if (done_o) done_cnt++;
    prev_req = wr_req_o;
    if (m_req != 0) age = (m_was_req != 0) ? age + 1 : 0;
    m_was_req = m_req;
    if (m_req != 0) ack = (ack_wait >= 0 && age >= ack_wait);
    else            ack = noise && ($urandom_range(0, 3) == 0);
  endtask

  task automatic press(input logic [4:0] m);
    {ent, arriba, abajo, izq, der} = m;
    cycle();
    {ent, arriba, abajo, izq, der} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_to_view(input string tag, input int budget);
    int n;
    n = 0;
    while (ph != P_VIEW && n < budget) begin cycle(); n++; end
    chk(tag, 64'(n < budget), 64'(1));
  endtask

  initial begin
    int n;
    logic [63:0] r;

    // Reset held two cycles with keys toggling.
    for (int i = 0; i < 2; i++) begin
      {ent, arriba, abajo, izq, der} = 5'($urandom);
      ack = 1'($urandom);
      cycle();
      chk("rst_edit_mode", 64'(edit_mode_o), 64'(0));
      chk("rst_wr_req", 64'(wr_req_o), 64'(0));
    end
    {ent, arriba, abajo, izq, der} = '0;
    ack = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // hour 23 / min 59 wrap upward.
    cur = {7'd24, 7'd6, 7'd1, 7'd30, 7'd59, 7'd23};
    press(5'b10000);
    idle(1);
    press(5'b01000);
    press(5'b00001);
    press(5'b01000);
    chk("s2_hour", 64'(edit_data_o[6:0]), 64'(0));
    chk("s2_min", 64'(edit_data_o[13:7]), 64'(0));
    chk("s2_cursor", 64'(cursor_o), 64'(1));

    // day 1 wraps down to 31, cursor wraps left to 5.
    press(5'b00001);
    press(5'b00001);
    press(5'b00100);
    chk("s3_day", 64'(edit_data_o[27:21]), 64'(31));
    repeat (4) press(5'b00010);
    chk("s3_cursor", 64'(cursor_o), 64'(5));

    // ent+arriba together commits; ack arrives after 3 cycles.
    ack_wait = 3;
    addr_log.delete();
    done_cnt = 0;
    press(5'b11000);
    run_to_view("s4_budget", 150);
    chk("s4_done_pulses", 64'(done_cnt), 64'(1));
    chk("s4_req_count", 64'(addr_log.size()), 64'(6));
    for (int i = 0; i < addr_log.size(); i++) chk("s4_addr_order", 64'(addr_log[i]), 64'(i));
    chk("s4_year_kept", 64'(edit_data_o[41:35]), 64'(24));

    // No ack: request times out after TO cycles.
    ack_wait = -1;
    press(5'b10000);
    idle(1);
    req_cycles = 0;
    press(5'b10000);
    idle(12);
    chk("s5_req_cycles", 64'(req_cycles), 64'(TO));
    chk("s5_error", 64'(error_o), 64'(1));
    chk("s5_view", 64'(edit_mode_o), 64'(0));
    press(5'b10000);
    chk("s5_error_clr", 64'(error_o), 64'(0));
    idle(1);

    // Reset during the field-2 write.
    press(5'b00001);
    ack_wait = 1;
    press(5'b10000);
    n = 0;
    while (!(m_req != 0 && m_addr == 2) && n < 60) begin cycle(); n++; end
    chk("s6_reach_f2", 64'(n < 60), 64'(1));
    rst_n = 1'b0;
    cycle();
    chk("s6_req", 64'(wr_req_o), 64'(0));
    chk("s6_cursor", 64'(cursor_o), 64'(0));
    chk("s6_edit_mode", 64'(edit_mode_o), 64'(0));
    rst_n = 1'b1;
    idle(1);

    // Randomized sessions with spurious keys/acks and out-of-range live values.
    noise = 1'b1;
    for (int s = 0; s < 30; s++) begin
      r = {$urandom, $urandom};
      cur = r[41:0];
      press({1'b0, 4'($urandom)});
      press(5'b10000);
      idle(1);
      for (int i = 0; i < 24; i++) press({1'b0, 4'($urandom)});
      ack_wait = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      press({1'b1, 4'($urandom)});
      run_to_view("rnd_budget", 150);
      idle(1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
